// File: rtl/qdr_bist_pkg.sv
// Shared types and constants for the QDR BIST sequencer.
package qdr_bist_pkg;

    localparam int unsigned BIST_LANES  = 4;
    // Each pass consumes one seed per lane, so seeds advance by the lane count.
    localparam int unsigned SEED_STRIDE = BIST_LANES;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StStart,
        StWait,
        StRecover,
        StNext,
        StFinish
    } state_e;

    typedef enum logic {
        OWNER_CLIENT,
        OWNER_BIST
    } owner_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/qdr_cmd_mux.sv
// Registered two-way QDR command mux with outstanding-read counter and read-valid router.
module qdr_cmd_mux
    import qdr_bist_pkg::*;
#(
    parameter int unsigned ADDR_BITS        = 18,
    parameter int unsigned DATA_BITS        = 144,
    parameter int unsigned OUTSTANDING_BITS = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  owner_e                      owner,
    input  logic                        cli_ready,
    input  logic                        cli_rd_en,
    input  logic [ADDR_BITS-1:0]        cli_rd_addr,
    input  logic                        cli_wr_en,
    input  logic [ADDR_BITS-1:0]        cli_wr_addr,
    input  logic [DATA_BITS-1:0]        cli_wr_data,
    input  logic                        bist_rd_en,
    input  logic [ADDR_BITS-1:0]        bist_rd_addr,
    input  logic                        bist_wr_en,
    input  logic [ADDR_BITS-1:0]        bist_wr_addr,
    input  logic [DATA_BITS-1:0]        bist_wr_data,
    output logic                        ram_rd_en,
    output logic [ADDR_BITS-1:0]        ram_rd_addr,
    output logic                        ram_wr_en,
    output logic [ADDR_BITS-1:0]        ram_wr_addr,
    output logic [DATA_BITS-1:0]        ram_wr_data,
    input  logic                        ram_rd_valid,
    output logic                        cli_rd_valid,
    output logic                        bist_rd_valid,
    output logic [OUTSTANDING_BITS-1:0] outstanding,
    output logic                        pipe_busy
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else if (owner == OWNER_BIST) begin
            ram_rd_en   <= bist_rd_en;
            ram_rd_addr <= bist_rd_addr;
            ram_wr_en   <= bist_wr_en;
            ram_wr_addr <= bist_wr_addr;
            ram_wr_data <= bist_wr_data;
        end else begin
            // Client commands issued while not ready are dropped, not buffered.
            ram_rd_en   <= cli_rd_en & cli_ready;
            ram_rd_addr <= cli_rd_addr;
            ram_wr_en   <= cli_wr_en & cli_ready;
            ram_wr_addr <= cli_wr_addr;
            ram_wr_data <= cli_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({ram_rd_en, ram_rd_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Ownership only changes with nothing outstanding, so the current owner is the issuer.
    assign cli_rd_valid  = ram_rd_valid & (owner == OWNER_CLIENT);
    assign bist_rd_valid = ram_rd_valid & (owner == OWNER_BIST);
    assign pipe_busy     = ram_rd_en | ram_wr_en;

endmodule

// File: rtl/qdr_bist_sequencer.sv
// QDR BIST sequencer: quiesces client traffic, runs N seeded BIST passes, accumulates results.
// Optional build macro: QDR_BIST_STOP_ON_FAIL_EN ends the sequence after the first failing pass.
module qdr_bist_sequencer
    import qdr_bist_pkg::*;
#(
    parameter int unsigned ADDR_BITS        = 18,
    parameter int unsigned DATA_BITS        = 144,
    parameter int unsigned OUTSTANDING_BITS = 6,
    parameter int unsigned TIMEOUT_CYCLES   = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic [15:0]          cmd_passes,
    input  logic [31:0]          cmd_seed,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          pass_count,
    output logic [15:0]          fail_count,
    output logic                 timeout,
    output logic [ADDR_BITS-1:0] first_fail_addr,
    output logic [15:0]          first_fail_pass,
    input  logic                 cli_rd_en,
    input  logic [ADDR_BITS-1:0] cli_rd_addr,
    input  logic                 cli_wr_en,
    input  logic [ADDR_BITS-1:0] cli_wr_addr,
    input  logic [DATA_BITS-1:0] cli_wr_data,
    output logic                 cli_ready,
    output logic                 cli_rd_valid,
    output logic                 bist_start,
    output logic [31:0]          bist_seed,
    input  logic                 bist_done,
    input  logic                 bist_fail,
    input  logic [ADDR_BITS-1:0] bist_fail_addr,
    input  logic                 bist_rd_en,
    input  logic [ADDR_BITS-1:0] bist_rd_addr,
    input  logic                 bist_wr_en,
    input  logic [ADDR_BITS-1:0] bist_wr_addr,
    input  logic [DATA_BITS-1:0] bist_wr_data,
    output logic                 bist_rd_valid,
    output logic                 ram_rd_en,
    output logic [ADDR_BITS-1:0] ram_rd_addr,
    output logic                 ram_wr_en,
    output logic [ADDR_BITS-1:0] ram_wr_addr,
    output logic [DATA_BITS-1:0] ram_wr_data,
    input  logic                 ram_rd_valid
);

    state_e                      state_q, state_d;
    owner_e                      owner_q, owner_d;
    logic [15:0]                 passes_q, passes_d;
    logic [31:0]                 seed_q, seed_d;
    logic [31:0]                 timer_q, timer_d;
    logic [15:0]                 pass_count_d, fail_count_d, first_fail_pass_d;
    logic [ADDR_BITS-1:0]        first_fail_addr_d;
    logic                        timeout_d, done_d, cli_ready_d, bist_start_d;
    logic [31:0]                 bist_seed_d;
    logic [OUTSTANDING_BITS-1:0] outstanding;
    logic                        pipe_busy;

    qdr_cmd_mux #(
        .ADDR_BITS        (ADDR_BITS),
        .DATA_BITS        (DATA_BITS),
        .OUTSTANDING_BITS (OUTSTANDING_BITS)
    ) u_cmd_mux (
        .clk           (clk),
        .rst           (rst),
        .owner         (owner_q),
        .cli_ready     (cli_ready),
        .cli_rd_en     (cli_rd_en),
        .cli_rd_addr   (cli_rd_addr),
        .cli_wr_en     (cli_wr_en),
        .cli_wr_addr   (cli_wr_addr),
        .cli_wr_data   (cli_wr_data),
        .bist_rd_en    (bist_rd_en),
        .bist_rd_addr  (bist_rd_addr),
        .bist_wr_en    (bist_wr_en),
        .bist_wr_addr  (bist_wr_addr),
        .bist_wr_data  (bist_wr_data),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_rd_valid  (ram_rd_valid),
        .cli_rd_valid  (cli_rd_valid),
        .bist_rd_valid (bist_rd_valid),
        .outstanding   (outstanding),
        .pipe_busy     (pipe_busy)
    );

    assign busy = (state_q != StIdle);

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        passes_d          = passes_q;
        seed_d            = seed_q;
        timer_d           = timer_q;
        pass_count_d      = pass_count;
        fail_count_d      = fail_count;
        first_fail_pass_d = first_fail_pass;
        first_fail_addr_d = first_fail_addr;
        timeout_d         = timeout;
        done_d            = done;
        cli_ready_d       = cli_ready;
        bist_start_d      = 1'b0;
        bist_seed_d       = bist_seed;
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    passes_d          = (cmd_passes == 16'd0) ? 16'd1 : cmd_passes;
                    seed_d            = cmd_seed;
                    pass_count_d      = '0;
                    fail_count_d      = '0;
                    first_fail_pass_d = '0;
                    first_fail_addr_d = '0;
                    timeout_d         = 1'b0;
                    done_d            = 1'b0;
                    cli_ready_d       = 1'b0;
                    state_d           = StDrain;
                end
            end
            StDrain: begin
                if (outstanding == '0 && !pipe_busy) begin
                    owner_d = OWNER_BIST;
                    state_d = StStart;
                end
            end
            StStart: begin
                bist_seed_d  = seed_q + 32'(SEED_STRIDE) * {16'd0, pass_count};
                bist_start_d = 1'b1;
                timer_d      = '0;
                state_d      = StWait;
            end
            StWait: begin
                timer_d = timer_q + 32'd1;
                // bist_done is still the previous pass's level while bist_start is high.
                if (!bist_start && bist_done) begin
                    pass_count_d = sat_inc(pass_count);
                    if (bist_fail) begin
                        fail_count_d = sat_inc(fail_count);
                        if (fail_count == 16'd0) begin
                            first_fail_addr_d = bist_fail_addr;
                            first_fail_pass_d = pass_count;
                        end
                    end
                    state_d = StNext;
                end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d    = 1'b1;
                    pass_count_d = sat_inc(pass_count);
                    fail_count_d = sat_inc(fail_count);
                    state_d      = StRecover;
                end
            end
            StRecover: begin
                if (outstanding == '0) state_d = StNext;
            end
            StNext: begin
`ifdef QDR_BIST_STOP_ON_FAIL_EN
                if (pass_count == passes_q || fail_count != 16'd0) state_d = StFinish;
                else state_d = StStart;
`else
                if (pass_count == passes_q) state_d = StFinish;
                else state_d = StStart;
`endif
            end
            StFinish: begin
                owner_d     = OWNER_CLIENT;
                cli_ready_d = 1'b1;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            owner_q         <= OWNER_CLIENT;
            passes_q        <= '0;
            seed_q          <= '0;
            timer_q         <= '0;
            pass_count      <= '0;
            fail_count      <= '0;
            first_fail_pass <= '0;
            first_fail_addr <= '0;
            timeout         <= 1'b0;
            done            <= 1'b0;
            cli_ready       <= 1'b1;
            bist_start      <= 1'b0;
            bist_seed       <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            passes_q        <= passes_d;
            seed_q          <= seed_d;
            timer_q         <= timer_d;
            pass_count      <= pass_count_d;
            fail_count      <= fail_count_d;
            first_fail_pass <= first_fail_pass_d;
            first_fail_addr <= first_fail_addr_d;
            timeout         <= timeout_d;
            done            <= done_d;
            cli_ready       <= cli_ready_d;
            bist_start      <= bist_start_d;
            bist_seed       <= bist_seed_d;
        end
    end

endmodule

// File: tb/tb_qdr_bist_sequencer.sv
// Directed bench for qdr_bist_sequencer with a small behavioural BIST engine model.
module tb_qdr_bist_sequencer;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 144;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic [15:0]   cmd_passes = '0;
    logic [31:0]   cmd_seed = '0;
    logic          busy, done, timeout, cli_ready, cli_rd_valid;
    logic [15:0]   pass_count, fail_count, first_fail_pass;
    logic [AW-1:0] first_fail_addr;
    logic          cli_rd_en = 1'b0, cli_wr_en = 1'b0;
    logic [AW-1:0] cli_rd_addr = '0, cli_wr_addr = '0;
    logic [DW-1:0] cli_wr_data = '0;
    logic          bist_start, bist_rd_valid;
    logic [31:0]   bist_seed;
    logic          bist_done = 1'b0, bist_fail = 1'b0;
    logic [AW-1:0] bist_fail_addr = '0;
    logic          bist_rd_en = 1'b0, bist_wr_en = 1'b0;
    logic [AW-1:0] bist_rd_addr = '0, bist_wr_addr = '0;
    logic [DW-1:0] bist_wr_data = '0;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd_valid = 1'b0;

    int checks = 0;
    int passed = 0;

    // BIST engine model state; only the model process writes bist_done/fail/fail_addr.
    int          starts = 0;
    int          lat = 0;
    bit          clear_pend = 1'b0;
    logic [31:0] seeds[64];
    int          model_hang = 0;
    int          fail_at = -1;

    always #5 clk = ~clk;

    qdr_bist_sequencer #(
        .ADDR_BITS        (AW),
        .DATA_BITS        (DW),
        .OUTSTANDING_BITS (6),
        .TIMEOUT_CYCLES   (100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_start       (cmd_start),
        .cmd_passes      (cmd_passes),
        .cmd_seed        (cmd_seed),
        .busy            (busy),
        .done            (done),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .timeout         (timeout),
        .first_fail_addr (first_fail_addr),
        .first_fail_pass (first_fail_pass),
        .cli_rd_en       (cli_rd_en),
        .cli_rd_addr     (cli_rd_addr),
        .cli_wr_en       (cli_wr_en),
        .cli_wr_addr     (cli_wr_addr),
        .cli_wr_data     (cli_wr_data),
        .cli_ready       (cli_ready),
        .cli_rd_valid    (cli_rd_valid),
        .bist_start      (bist_start),
        .bist_seed       (bist_seed),
        .bist_done       (bist_done),
        .bist_fail       (bist_fail),
        .bist_fail_addr  (bist_fail_addr),
        .bist_rd_en      (bist_rd_en),
        .bist_rd_addr    (bist_rd_addr),
        .bist_wr_en      (bist_wr_en),
        .bist_wr_addr    (bist_wr_addr),
        .bist_wr_data    (bist_wr_data),
        .bist_rd_valid   (bist_rd_valid),
        .ram_rd_en       (ram_rd_en),
        .ram_rd_addr     (ram_rd_addr),
        .ram_wr_en       (ram_wr_en),
        .ram_wr_addr     (ram_wr_addr),
        .ram_wr_data     (ram_wr_data),
        .ram_rd_valid    (ram_rd_valid)
    );

    // Engine keeps its old done level for one cycle after seeing bist_start.
    always @(negedge clk) begin
        if (clear_pend) begin
            bist_done  = 1'b0;
            bist_fail  = 1'b0;
            clear_pend = 1'b0;
        end
        if (bist_start) begin
            if (starts < 64) seeds[starts] = bist_seed;
            starts     = starts + 1;
            lat        = 6;
            clear_pend = 1'b1;
        end else if (lat > 0) begin
            lat = lat - 1;
            if (lat == 0 && model_hang == 0) begin
                bist_done      = 1'b1;
                bist_fail      = ((starts - 1) == fail_at);
                bist_fail_addr = ((starts - 1) == fail_at) ? 18'h2abcd : 18'h0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic launch(input logic [15:0] passes, input logic [31:0] seed);
        cmd_passes = passes;
        cmd_seed   = seed;
        cmd_start  = 1'b1;
        tick();
        cmd_start  = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        tick();
        tick();
        got = {busy, cli_ready, done, timeout, ram_rd_en, ram_wr_en, bist_start, cli_rd_valid};
        checks++;
        if (got !== 8'b0100_0000) $display("FAIL reset_flags got %b want 01000000", got);
        else passed++;
        checks++;
        if ({pass_count, fail_count} !== 32'd0)
            $display("FAIL reset_counters got %h/%h want 0/0", pass_count, fail_count);
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_passthrough();
        cli_wr_en    = 1'b1;
        cli_wr_addr  = 18'h00010;
        cli_wr_data  = 144'hdead_beef_0123_4567_89ab_cdef_5a5a_a5a5_1234;
        bist_wr_en   = 1'b1;
        bist_wr_addr = 18'h3ffff;
        tick();
        checks++;
        if ({ram_wr_en, ram_rd_en, ram_wr_addr} !== {2'b10, 18'h00010})
            $display("FAIL idle_wr got en=%b%b addr=%h want 10 00010",
                     ram_wr_en, ram_rd_en, ram_wr_addr);
        else passed++;
        checks++;
        if (ram_wr_data !== 144'hdead_beef_0123_4567_89ab_cdef_5a5a_a5a5_1234)
            $display("FAIL idle_wr_data got %h", ram_wr_data);
        else passed++;
        cli_wr_en   = 1'b0;
        bist_wr_en  = 1'b0;
        cli_rd_en   = 1'b1;
        cli_rd_addr = 18'h00010;
        tick();
        checks++;
        if ({ram_rd_en, ram_wr_en, ram_rd_addr} !== {2'b10, 18'h00010})
            $display("FAIL idle_rd got en=%b%b addr=%h want 10 00010",
                     ram_rd_en, ram_wr_en, ram_rd_addr);
        else passed++;
        cli_rd_en = 1'b0;
        tick();
        ram_rd_valid = 1'b1;
        #1;
        checks++;
        if ({cli_rd_valid, bist_rd_valid} !== 2'b10)
            $display("FAIL idle_rd_route got %b%b want 10", cli_rd_valid, bist_rd_valid);
        else passed++;
        tick();
        ram_rd_valid = 1'b0;
        tick();
    endtask

    task automatic test_drain();
        int early = 0;
        int routed = 0;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            cli_rd_en   = 1'b1;
            cli_rd_addr = 18'(i + 1);
            tick();
        end
        cli_rd_en = 1'b0;
        launch(16'd1, 32'h500);
        checks++;
        if ({cli_ready, busy} !== 2'b01)
            $display("FAIL drain_ready got ready=%b busy=%b want 0 1", cli_ready, busy);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            if (bist_start !== 1'b0) early++;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            ram_rd_valid = 1'b1;
            #1;
            if (cli_rd_valid === 1'b1 && bist_rd_valid === 1'b0) routed++;
            if (bist_start !== 1'b0) early++;
            tick();
        end
        ram_rd_valid = 1'b0;
        checks++;
        if (early !== 0) $display("FAIL drain_early_start got %0d starts want 0", early);
        else passed++;
        checks++;
        if (routed !== 5) $display("FAIL drain_route got %0d want 5", routed);
        else passed++;
        wait_done(200, ok);
        checks++;
        if (!ok || pass_count !== 16'd1)
            $display("FAIL drain_complete got done=%b pass=%0d want 1 1", ok, pass_count);
        else passed++;
    endtask

    task automatic test_three_passes();
        int base = starts;
        bit ok;
        launch(16'd3, 32'h1000);
        checks++;
        if ({done, pass_count} !== {1'b0, 16'd0})
            $display("FAIL start_clears got done=%b pass=%0d want 0 0", done, pass_count);
        else passed++;
        wait_done(500, ok);
        checks++;
        if (!ok || (starts - base) !== 3)
            $display("FAIL p3_starts got ok=%b starts=%0d want 1 3", ok, starts - base);
        else passed++;
        checks++;
        if ({seeds[base], seeds[base+1], seeds[base+2]} !== {32'h1000, 32'h1004, 32'h1008})
            $display("FAIL p3_seeds got %h %h %h want 1000 1004 1008",
                     seeds[base], seeds[base+1], seeds[base+2]);
        else passed++;
        checks++;
        if ({pass_count, fail_count, done, cli_ready, busy, timeout} !==
            {16'd3, 16'd0, 4'b1100})
            $display("FAIL p3_status got pass=%0d fail=%0d flags=%b%b%b%b want 3 0 1100",
                     pass_count, fail_count, done, cli_ready, busy, timeout);
        else passed++;
    endtask

    task automatic test_fail_pass();
        logic [15:0] exp_pass;
        bit ok;
        fail_at = starts + 1;
`ifdef QDR_BIST_STOP_ON_FAIL_EN
        exp_pass = 16'd2;
`else
        exp_pass = 16'd3;
`endif
        launch(16'd3, 32'h2000);
        wait_done(500, ok);
        fail_at = -1;
        checks++;
        if (!ok || fail_count !== 16'd1 || pass_count !== exp_pass)
            $display("FAIL fail_counts got ok=%b pass=%0d fail=%0d want 1 %0d 1",
                     ok, pass_count, fail_count, exp_pass);
        else passed++;
        checks++;
        if ({first_fail_pass, first_fail_addr} !== {16'd1, 18'h2abcd})
            $display("FAIL first_fail got pass=%0d addr=%h want 1 2abcd",
                     first_fail_pass, first_fail_addr);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [15:0] exp_n;
        bit ok;
`ifdef QDR_BIST_STOP_ON_FAIL_EN
        exp_n = 16'd1;
`else
        exp_n = 16'd2;
`endif
        model_hang = 1;
        launch(16'd2, 32'h3000);
        wait_done(1000, ok);
        model_hang = 0;
        checks++;
        if (!ok || timeout !== 1'b1 || fail_count !== exp_n || pass_count !== exp_n)
            $display("FAIL timeout got ok=%b to=%b pass=%0d fail=%0d want 1 1 %0d %0d",
                     ok, timeout, pass_count, fail_count, exp_n, exp_n);
        else passed++;
        checks++;
        if ({cli_ready, busy} !== 2'b10)
            $display("FAIL timeout_idle got ready=%b busy=%b want 1 0", cli_ready, busy);
        else passed++;
    endtask

    task automatic test_zero_passes();
        int base = starts;
        bit ok;
        launch(16'd0, 32'h4000);
        wait_done(200, ok);
        checks++;
        if (!ok || pass_count !== 16'd1 || (starts - base) !== 1 || timeout !== 1'b0)
            $display("FAIL zero_passes got ok=%b pass=%0d starts=%0d to=%b want 1 1 1 0",
                     ok, pass_count, starts - base, timeout);
        else passed++;
    endtask

    task automatic test_reset_in_wait();
        int base = starts;
        logic [7:0] got;
        launch(16'd3, 32'h40);
        for (int i = 0; i < 300 && starts < base + 2; i++) tick();
        tick();
        bist_rd_en   = 1'b1;
        bist_rd_addr = 18'h00005;
        tick();
        checks++;
        if ({busy, ram_rd_en, pass_count} !== {2'b11, 16'd1})
            $display("FAIL pre_reset got busy=%b rd=%b pass=%0d want 1 1 1",
                     busy, ram_rd_en, pass_count);
        else passed++;
        rst = 1'b1;
        #1;
        got = {busy, cli_ready, ram_rd_en, ram_wr_en, bist_start, done, timeout, 1'b0};
        checks++;
        if (got !== 8'b0100_0000 || {pass_count, fail_count} !== 32'd0)
            $display("FAIL mid_reset got flags=%b pass=%0d fail=%0d want 01000000 0 0",
                     got, pass_count, fail_count);
        else passed++;
        bist_rd_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        cli_wr_en   = 1'b1;
        cli_wr_addr = 18'h00077;
        tick();
        cli_wr_en = 1'b0;
        checks++;
        if ({ram_wr_en, ram_wr_addr} !== {1'b1, 18'h00077})
            $display("FAIL post_reset_client got en=%b addr=%h want 1 00077",
                     ram_wr_en, ram_wr_addr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_idle_passthrough();
        test_drain();
        test_three_passes();
        test_fail_pass();
        test_timeout();
        test_zero_passes();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/qdr_bist_sequencer.md
Name: qdr_bist_sequencer

Overview:
- Sits between the ingress packet-buffer client, the QDR memory BIST engine and the QDR controller user port.
- Owns the controller's read/write command bus and muxes it between the functional client and the BIST engine.
- On command, quiesces client traffic and drains in-flight reads. It then runs N BIST passes with distinct seeds and accumulates results for the management interface.

Parameters:
ADDR_BITS, 18, QDR word address width
DATA_BITS, 144, QDR word data width
OUTSTANDING_BITS, 6, width of in-flight read counter (max 2^6-1 reads)
TIMEOUT_CYCLES, 2000000, max cycles per pass before the pass is declared hung

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous active-high
cmd_start  in  1  pulse: begin test sequence (ignored unless idle)
cmd_passes  in  16  number of passes (0 treated as 1)
cmd_seed  in  32  base seed
busy  out  1  sequence in progress
done  out  1  held high after sequence completes, cleared by cmd_start
pass_count  out  16  passes completed
fail_count  out  16  passes that failed or timed out
timeout  out  1  sticky: any pass hit timeout
first_fail_addr  out  ADDR_BITS  fail address of first failing pass
first_fail_pass  out  16  index of first failing pass
cli_rd_en, cli_rd_addr, cli_wr_en, cli_wr_addr, cli_wr_data  in  1/ADDR/1/ADDR/DATA  client commands
cli_ready  out  1  client may issue commands this cycle
cli_rd_valid  out  1  read return for client
bist_start  out  1  pulse to BIST engine
bist_seed  out  32  seed to BIST engine
bist_done, bist_fail  in  1  BIST level status
bist_fail_addr  in  ADDR_BITS  BIST first fail address
bist_rd_en, bist_rd_addr, bist_wr_en, bist_wr_addr, bist_wr_data  in  1/ADDR/1/ADDR/DATA  BIST commands
bist_rd_valid  out  1  read return for BIST
ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data  out  1/ADDR/1/ADDR/DATA  to controller
ram_rd_valid  in  1  read return from controller (data bus fans out directly to both consumers)

Behaviour:
- Reset: all outputs 0 except cli_ready=1; state IDLE; counters 0.
- Command mux is registered: one cycle latency from cli_*/bist_* to ram_*. The non-owner's enables are forced 0; addr/data pass through from the owner.
- Client commands issued while cli_ready=0 are dropped (client contract violation, not buffered).
- Outstanding counter: +1 on ram_rd_en, -1 on ram_rd_valid; both in same cycle leaves it unchanged. ram_rd_valid routes to cli_rd_valid or bist_rd_valid by the owner latched at issue. Ownership changes only at outstanding==0, so routing uses the current owner.
- States:
  - IDLE: cli_ready=1. On cmd_start: latch passes/seed, clear counters, timeout, done and first_fail_*; cli_ready<=0; go DRAIN.
  - DRAIN: wait until outstanding==0 and no command is in the mux pipeline; owner<=BIST; go START.
  - START: bist_seed<=cmd_seed + 4*pass_count (engine uses seed+0..3 per lane), pulse bist_start one cycle, reset timer; go WAIT.
  - WAIT: ignore bist_done on the first cycle after bist_start (stale level). Afterwards, bist_done=1 -> pass_count+1. If bist_fail: fail_count+1, and if fail_count was 0 capture first_fail_addr/first_fail_pass. Then go NEXT. Timer reaching TIMEOUT_CYCLES-1 -> timeout=1, fail_count+1, go RECOVER.
  - RECOVER: wait outstanding==0; go NEXT. Reads that never return keep the block here; only reset clears it.
  - NEXT: if pass_count==passes go FINISH, else START.
  - FINISH: owner<=client; cli_ready<=1; done<=1; go IDLE.
- busy=1 in every state except IDLE.
- Counters saturate at 16'hffff.
- cmd_start outside IDLE is ignored.
- Async reset mid-sequence: returns immediately to IDLE with client ownership. The BIST engine is not reset by this block.

Optional Feature:
QDR_BIST_STOP_ON_FAIL_EN
- Defined: a failing or timed-out pass skips remaining passes; NEXT goes directly to FINISH; pass_count reflects passes actually run.
- Undefined: all requested passes always run.

Decomposition:
- Package qdr_bist_pkg: state enum, BIST lane count constant (4) and seed stride (4), owner enum (OWNER_CLIENT/OWNER_BIST).
- One sub-module: qdr_cmd_mux, the registered two-way command mux plus outstanding-read counter and read-valid router.

Test Plan:
- Idle passthrough: client write addr 0x00010 data X then read -> ram_wr_en/ram_rd_en 1 cycle later; valid routed to cli_rd_valid only.
- Drain: client issues 5 reads, cmd_start next cycle, returns delayed 20 cycles -> bist_start not asserted until 5th valid; cli_ready=0 from cycle after cmd_start.
- 3 passes, seed 0x1000, model BIST passes -> bist_seed 0x1000, 0x1004, 0x1008; pass_count=3, fail_count=0, done=1, cli_ready=1.
- 3 passes, model fails pass 1 at addr 0x2abcd -> fail_count=1, first_fail_pass=1, first_fail_addr=0x2abcd; with STOP_ON_FAIL_EN, pass_count=2.
- Model never asserts bist_done, TIMEOUT_CYCLES=100 -> timeout=1, fail_count=1 per pass, sequence completes.
- Assert rst during WAIT -> next cycle busy=0, cli_ready=1, ram enables 0, counters 0.
